// File: rtl/asynchronous_d_ff.sv
`timescale 1ns/1ps
// asynchronous_d_ff
// Two-stage capture chain for a D input with no fixed phase relation to CLK.
// Q1 is the first-stage capture (debug / timing comparison only); Q2 is the
// resynchronised output that downstream synchronous logic consumes.
// Optional build macro ASYNC_D_FF_EDGE_EN adds a third stage and one-cycle
// Q_RISE / Q_FALL edge pulses aligned with each Q2 change.
module asynchronous_d_ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
`ifdef ASYNC_D_FF_EDGE_EN
    ,
    output logic [WIDTH-1:0] Q_RISE,
    output logic [WIDTH-1:0] Q_FALL
`endif
);

    // Reject widths outside the supported range at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("asynchronous_d_ff: WIDTH must be in 1..64");
        end
    endgenerate

    // Stage registers; every bit is an independent flop, no cross-bit coherency.
    logic [WIDTH-1:0] cap_p0;
    logic [WIDTH-1:0] cap_p1;

    // Stage p0: sample D at the rising edge; reset overrides the data path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_p0 <= RESET_VAL;
        end else begin
            cap_p0 <= D;
        end
    end

    // Stage p1: resynchronising stage, takes the previous first-stage value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_p1 <= RESET_VAL;
        end else begin
            cap_p1 <= cap_p0;
        end
    end

    // Outputs come straight from flops: no combinational path from D or RST.
    assign Q1 = cap_p0;
    assign Q2 = cap_p1;

`ifdef ASYNC_D_FF_EDGE_EN
    logic [WIDTH-1:0] cap_p2;

    // Stage p2: one-cycle history of Q2, reset together with the chain so a
    // reset never manufactures a spurious edge pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_p2 <= RESET_VAL;
        end else begin
            cap_p2 <= cap_p1;
        end
    end

    // Edge pulses are high for exactly the cycle in which Q2 changes.
    assign Q_RISE = cap_p1 & ~cap_p2;
    assign Q_FALL = ~cap_p1 & cap_p2;
`endif

endmodule

// File: tb/tb_asynchronous_d_ff.sv
`timescale 1ns/1ps
// Directed bench for asynchronous_d_ff: timeline with CLK rising at 5, 15, 25 ns ...
module tb_asynchronous_d_ff;

    logic       CLK;
    logic       RST;
    logic       D;
    logic       Q1, Q2;
    logic [7:0] D8, Q1_8, Q2_8;
`ifdef ASYNC_D_FF_EDGE_EN
    logic       Q_RISE, Q_FALL;
    logic [7:0] Q_RISE8, Q_FALL8;
`endif

    int checks = 0;
    int errors = 0;

    asynchronous_d_ff #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
        .CLK(CLK), .RST(RST), .D(D), .Q1(Q1), .Q2(Q2)
`ifdef ASYNC_D_FF_EDGE_EN
        , .Q_RISE(Q_RISE), .Q_FALL(Q_FALL)
`endif
    );

    asynchronous_d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .CLK(CLK), .RST(RST), .D(D8), .Q1(Q1_8), .Q2(Q2_8)
`ifdef ASYNC_D_FF_EDGE_EN
        , .Q_RISE(Q_RISE8), .Q_FALL(Q_FALL8)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic test_capture;
        at(0); D = 1'b1; RST = 1'b0; D8 = 8'h3C;
        at(6);
        checks++; if (Q1 !== 1'b1) begin errors++; $display("FAIL cap_q1_e5 got %b exp 1", Q1); end
        checks++; if (Q1_8 !== 8'h3C) begin errors++; $display("FAIL cap_q1_8_e5 got %h exp 3c", Q1_8); end
    endtask

    task automatic test_falling;
        at(11); D = 1'b0;
        at(16);
        checks++; if (Q1 !== 1'b0) begin errors++; $display("FAIL fall_q1_e15 got %b exp 0", Q1); end
        checks++; if (Q2 !== 1'b1) begin errors++; $display("FAIL fall_q2_e15 got %b exp 1", Q2); end
        checks++; if (Q2_8 !== 8'h3C) begin errors++; $display("FAIL cap_q2_8_e15 got %h exp 3c", Q2_8); end
        at(23); D = 1'b1;
        at(26);
        checks++; if (Q1 !== 1'b1) begin errors++; $display("FAIL fall_q1_e25 got %b exp 1", Q1); end
        checks++; if (Q2 !== 1'b0) begin errors++; $display("FAIL fall_q2_e25 got %b exp 0", Q2); end
`ifdef ASYNC_D_FF_EDGE_EN
        checks++; if (Q_FALL !== 1'b1) begin errors++; $display("FAIL edge_fall_e25 got %b exp 1", Q_FALL); end
        checks++; if (Q_RISE !== 1'b0) begin errors++; $display("FAIL edge_rise_e25 got %b exp 0", Q_RISE); end
`endif
        at(33);
        checks++; if (Q2 !== 1'b0) begin errors++; $display("FAIL fall_q2_t33 got %b exp 0", Q2); end
    endtask

    task automatic test_mid_reset;
        at(36); RST = 1'b1;
        at(40);
        checks++; if (Q1 !== 1'b1) begin errors++; $display("FAIL midrst_q1_t40 got %b exp 1", Q1); end
        checks++; if (Q2 !== 1'b1) begin errors++; $display("FAIL midrst_q2_t40 got %b exp 1", Q2); end
        at(44);
        checks++; if (Q2 !== 1'b1) begin errors++; $display("FAIL midrst_q2_t44 got %b exp 1", Q2); end
        checks++; if (Q1_8 !== 8'h3C) begin errors++; $display("FAIL midrst_q1_8_t44 got %h exp 3c", Q1_8); end
        at(46);
        checks++; if (Q1 !== 1'b0) begin errors++; $display("FAIL rst_q1_e45 got %b exp 0", Q1); end
        checks++; if (Q2 !== 1'b0) begin errors++; $display("FAIL rst_q2_e45 got %b exp 0", Q2); end
        checks++; if (Q1_8 !== 8'hA5) begin errors++; $display("FAIL rst_q1_8_e45 got %h exp a5", Q1_8); end
        checks++; if (Q2_8 !== 8'hA5) begin errors++; $display("FAIL rst_q2_8_e45 got %h exp a5", Q2_8); end
`ifdef ASYNC_D_FF_EDGE_EN
        checks++; if (Q_FALL !== 1'b0) begin errors++; $display("FAIL rst_fall_e45 got %b exp 0", Q_FALL); end
        checks++; if (Q_RISE8 !== 8'h00) begin errors++; $display("FAIL rst_rise8_e45 got %h exp 00", Q_RISE8); end
`endif
    endtask

    task automatic test_reset_dominance;
        at(47); D = 1'b0;
        at(56);
        checks++; if (Q1 !== 1'b0 || Q2 !== 1'b0) begin errors++; $display("FAIL rstdom_e55 got %b%b exp 00", Q1, Q2); end
        at(59); D = 1'b1;
        at(66);
        checks++; if (Q1 !== 1'b0 || Q2 !== 1'b0) begin errors++; $display("FAIL rstdom_e65 got %b%b exp 00", Q1, Q2); end
        checks++; if (Q1_8 !== 8'hA5) begin errors++; $display("FAIL rstdom_q1_8_e65 got %h exp a5", Q1_8); end
    endtask

    task automatic test_reset_release;
        at(72); RST = 1'b0;
        at(76);
        checks++; if (Q1 !== 1'b1) begin errors++; $display("FAIL rel_q1_e75 got %b exp 1", Q1); end
        checks++; if (Q2 !== 1'b0) begin errors++; $display("FAIL rel_q2_e75 got %b exp 0", Q2); end
        checks++; if (Q1_8 !== 8'h3C) begin errors++; $display("FAIL rel_q1_8_e75 got %h exp 3c", Q1_8); end
        checks++; if (Q2_8 !== 8'hA5) begin errors++; $display("FAIL rel_q2_8_e75 got %h exp a5", Q2_8); end
        at(86);
        checks++; if (Q2 !== 1'b1) begin errors++; $display("FAIL rel_q2_e85 got %b exp 1", Q2); end
        checks++; if (Q2_8 !== 8'h3C) begin errors++; $display("FAIL rel_q2_8_e85 got %h exp 3c", Q2_8); end
`ifdef ASYNC_D_FF_EDGE_EN
        checks++; if (Q_RISE !== 1'b1) begin errors++; $display("FAIL rel_rise_e85 got %b exp 1", Q_RISE); end
        checks++; if (Q_RISE8 !== 8'h18) begin errors++; $display("FAIL rel_rise8_e85 got %h exp 18", Q_RISE8); end
        checks++; if (Q_FALL8 !== 8'h81) begin errors++; $display("FAIL rel_fall8_e85 got %h exp 81", Q_FALL8); end
        at(96);
        checks++; if (Q_RISE !== 1'b0) begin errors++; $display("FAIL rel_rise_e95 got %b exp 0", Q_RISE); end
        checks++; if (Q_FALL8 !== 8'h00) begin errors++; $display("FAIL rel_fall8_e95 got %h exp 00", Q_FALL8); end
`endif
    endtask

    task automatic test_glitch;
        at(97); D = 1'b0;
        at(116);
        checks++; if (Q1 !== 1'b0 || Q2 !== 1'b0) begin errors++; $display("FAIL glitch_pre got %b%b exp 00", Q1, Q2); end
        D = 1'b1;
        at(119); D = 1'b0;
        at(126);
        checks++; if (Q1 !== 1'b0 || Q2 !== 1'b0) begin errors++; $display("FAIL glitch_e125 got %b%b exp 00", Q1, Q2); end
        at(136);
        checks++; if (Q1 !== 1'b0 || Q2 !== 1'b0) begin errors++; $display("FAIL glitch_e135 got %b%b exp 00", Q1, Q2); end
    endtask

    task automatic test_back_to_back;
        // D changes at 137, 147, ...; the pattern below is what lands on edges 145..185.
        logic [4:0] pat;
        logic       pq1;
        pat = 5'b10110;
        pq1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at(137 + 10 * i);
            D  = pat[4 - i];
            D8 = {4'(i), 4'(15 - i)};
            at(146 + 10 * i);
            checks++; if (Q1 !== pat[4 - i]) begin errors++; $display("FAIL b2b_q1_%0d got %b exp %b", i, Q1, pat[4 - i]); end
            checks++; if (Q2 !== pq1) begin errors++; $display("FAIL b2b_q2_%0d got %b exp %b", i, Q2, pq1); end
            checks++; if (Q1_8 !== {4'(i), 4'(15 - i)}) begin errors++; $display("FAIL b2b_q1_8_%0d got %h", i, Q1_8); end
            pq1 = pat[4 - i];
        end
    endtask

    initial begin
        RST = 1'b0;
        D   = 1'b0;
        D8  = 8'h00;
        test_capture();
        test_falling();
        test_mid_reset();
        test_reset_dominance();
        test_reset_release();
        test_glitch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/asynchronous_d_ff.md
Name: asynchronous_d_ff

Overview:
- Clocked capture stage for a D input that changes with no fixed phase relation to CLK.
- Two-stage register chain: Q1 is the first-stage capture of D; Q2 is the second-stage output, resynchronised to CLK.
- Sits at clock-domain or pad boundaries ahead of synchronous logic. Downstream logic consumes Q2; Q1 is exposed for debug and timing comparison only.

Parameters:
- WIDTH, 1, bit width of D, Q1 and Q2; legal range 1..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q1 and Q2 on reset.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high; sampled on the rising CLK edge.
- D  input  WIDTH  data input; may toggle at any time relative to CLK.
- Q1  output  WIDTH  first-stage register: D sampled at the last rising edge.
- Q2  output  WIDTH  second-stage register: Q1 delayed by one cycle.

Behaviour:
- Interface (already decided): one clock (CLK); reset RST is synchronous and active-high.
- Rising edge with RST=1: Q1 <= RESET_VAL and Q2 <= RESET_VAL. D is ignored.
- Rising edge with RST=0: Q1 <= D and Q2 <= old Q1.
- Latency: D to Q1 is 1 edge; D to Q2 is 2 edges.
- RST has no effect between edges. Asserting RST mid-cycle leaves Q1/Q2 unchanged until the next rising edge.
- RST held high for N edges: Q1 and Q2 stay at RESET_VAL for all N edges.
- First edge after RST deasserts: Q1 takes D; Q2 takes RESET_VAL (the old Q1).
- Before the first rising edge: Q1/Q2 are undefined (X in simulation). There is no power-up initial value.
- D toggling between edges: only the value present at the edge is captured. Glitches narrower than a period are invisible.
- All bits are independent; no cross-bit coherency guarantee for multi-bit D.
- No combinational path from D or RST to any output.
- Registers are flops only; no latches.

Optional Feature:
- Macro: ASYNC_D_FF_EDGE_EN.
- When defined, add two outputs:
  - Q_RISE, WIDTH: bitwise Q2 & ~Q3.
  - Q_FALL, WIDTH: bitwise ~Q2 & Q3.
  - Q3 is an internal third register (Q3 <= Q2) that resets to RESET_VAL with the others.
- Each pulse is exactly one cycle wide and aligned with the Q2 change.
- When not defined, Q_RISE, Q_FALL and Q3 do not exist. Port list and behaviour are exactly as above.

Test Plan:
All scenarios use a CLK period of 10 ns with rising edges at 5, 15, 25, ... ns, and WIDTH=1.
- Capture/latency: D=1, RST=0 from t=0 -> Q1=1 after edge 5; Q2=1 after edge 15.
- Falling data: D=0 at t=11 -> Q1=0 at edge 15, Q2=0 at edge 25. Then D=1 at t=23 -> Q1=1 at edge 25, Q2=1 at edge 35.
- Mid-cycle reset: RST=1 at t=36 -> Q1/Q2 unchanged during 36..44; both equal 0 after edge 45.
- Reset dominance: D=0 at t=47, D=1 at t=59, RST held high until t=72 -> Q1=Q2=0 at edges 45, 55, 65.
- Reset release: RST=0 at t=72 with D=1 -> Q1=1 and Q2=0 at edge 75; Q2=1 at edge 85. With ASYNC_D_FF_EDGE_EN: Q_RISE=1 for exactly one cycle (85..95).
- Sub-cycle glitch: D pulses 1 for 3 ns between edges (e.g. 16..19) with D=0 at both edges -> Q1 and Q2 never change.
